// File: rtl/app_mem_responder_if.sv
// Application-interface bundle between a DDR3-style initiator and its responder.
// Carries the command, write-data and read-data channels; clock and reset stay outside.
interface app_mem_responder_if #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]       app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic                        app_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_wdf_data;
  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                        app_wdf_end;
  logic                        app_wdf_wren;
  logic                        app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0]   app_rd_data;
  logic                        app_rd_data_valid;
  logic                        app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_end, app_wdf_wren,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_end, app_wdf_wren,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/app_mem_responder.sv
// Block-RAM backed responder for the DDR3 application interface (stand-in for ExternalMemory).
// Optional ready back-pressure LFSR is built when RESP_BACKPRESSURE_EN is defined.
module app_mem_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64,
  parameter int WDF_DEPTH_LOG2 = 2
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst,
  app_mem_responder_if.slave    app,
  output logic                  init_calib_complete,
  output logic                  ui_clk_sync_rst
);

  localparam int NBYTES    = APP_DATA_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int WDF_DEPTH = 1 << WDF_DEPTH_LOG2;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int WCNT_W    = WDF_DEPTH_LOG2 + 1;

  localparam logic [WCNT_W-1:0] WDF_FULL  = WCNT_W'(WDF_DEPTH);
  localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'(CALIB_CYCLES - 1);

  localparam logic [1:0] ST_CALIB      = 2'd0;
  localparam logic [1:0] ST_IDLE       = 2'd1;
  localparam logic [1:0] ST_WAIT_WDATA = 2'd2;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  logic [1:0]                 state_q, state_d;
  logic [CAL_W-1:0]           calib_cnt_q, calib_cnt_d;
  logic [MEM_DEPTH_LOG2-1:0]  waddr_q, waddr_d;
  logic                       sync_rst_q;

  logic [MEM_DEPTH_LOG2-1:0]  cmd_idx;
  logic                       cmd_rdy, wdf_rdy, cmd_acc, wdf_acc;
  logic                       bp_cmd_block, bp_wdf_block;

  logic                       wr_commit;
  logic [MEM_DEPTH_LOG2-1:0]  wr_idx;
  logic [APP_DATA_WIDTH-1:0]  wr_data;
  logic [NBYTES-1:0]          wr_mask;
  logic                       rd_acc;

  logic [APP_DATA_WIDTH-1:0]  wdf_data_mem [WDF_DEPTH];
  logic [NBYTES-1:0]          wdf_mask_mem [WDF_DEPTH];
  logic [WDF_DEPTH_LOG2-1:0]  wdf_wptr_q, wdf_rptr_q;
  logic [WCNT_W-1:0]          wdf_cnt_q;
  logic                       fifo_push, fifo_pop, fifo_empty;

  logic [APP_DATA_WIDTH-1:0]  mem_rd_word;
  logic [RD_LATENCY-1:0]      rd_vld_q;

  logic                       unused_ok;

  // Column address: the low three bits select within a burst and are not stored.
  assign cmd_idx = app.app_addr[MEM_DEPTH_LOG2+2:3];
  assign unused_ok = ^{app.app_wdf_end, app.app_addr};

`ifdef RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign bp_cmd_block = (lfsr_q[1:0] == 2'b00);
  assign bp_wdf_block = (lfsr_q[3:2] == 2'b00);
`else
  assign bp_cmd_block = 1'b0;
  assign bp_wdf_block = 1'b0;
`endif

  // Write-data ready uses pre-pop occupancy, so a full FIFO refuses a beat even while popping.
  assign cmd_rdy    = (state_q == ST_IDLE) && !bp_cmd_block;
  assign wdf_rdy    = (state_q != ST_CALIB) && (wdf_cnt_q != WDF_FULL) && !bp_wdf_block;
  assign cmd_acc    = app.app_en && cmd_rdy;
  assign wdf_acc    = app.app_wdf_wren && wdf_rdy;
  assign fifo_empty = (wdf_cnt_q == '0);

  assign app.app_rdy     = cmd_rdy;
  assign app.app_wdf_rdy = wdf_rdy;

  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    waddr_d     = waddr_q;
    wr_commit   = 1'b0;
    wr_idx      = cmd_idx;
    wr_data     = app.app_wdf_data;
    wr_mask     = app.app_wdf_mask;
    fifo_pop    = 1'b0;
    fifo_push   = wdf_acc;
    rd_acc      = 1'b0;

    case (state_q)
      ST_CALIB: begin
        calib_cnt_d = calib_cnt_q + 1'b1;
        if (calib_cnt_q == CAL_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_acc) begin
          if (app.app_cmd == CMD_WRITE) begin
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              wr_commit = 1'b1;
              wr_data   = wdf_data_mem[wdf_rptr_q];
              wr_mask   = wdf_mask_mem[wdf_rptr_q];
            end else if (wdf_acc) begin
              // Beat arriving alongside its command skips the FIFO.
              fifo_push = 1'b0;
              wr_commit = 1'b1;
            end else begin
              waddr_d = cmd_idx;
              state_d = ST_WAIT_WDATA;
            end
          end else if (app.app_cmd == CMD_READ) begin
            rd_acc = 1'b1;
          end
        end
      end
      ST_WAIT_WDATA: begin
        if (wdf_acc) begin
          fifo_push = 1'b0;
          wr_commit = 1'b1;
          wr_idx    = waddr_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CALIB;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_CALIB;
      calib_cnt_q <= '0;
      waddr_q     <= '0;
      sync_rst_q  <= 1'b1;
      wdf_wptr_q  <= '0;
      wdf_rptr_q  <= '0;
      wdf_cnt_q   <= '0;
      rd_vld_q    <= '0;
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
      waddr_q     <= waddr_d;
      sync_rst_q  <= 1'b0;
      if (fifo_push) begin
        wdf_wptr_q <= wdf_wptr_q + 1'b1;
      end
      if (fifo_pop) begin
        wdf_rptr_q <= wdf_rptr_q + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   wdf_cnt_q <= wdf_cnt_q + 1'b1;
        2'b01:   wdf_cnt_q <= wdf_cnt_q - 1'b1;
        default: wdf_cnt_q <= wdf_cnt_q;
      endcase
      rd_vld_q <= (rd_vld_q << 1) | RD_LATENCY'(rd_acc);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (fifo_push) begin
      wdf_data_mem[wdf_wptr_q] <= app.app_wdf_data;
      wdf_mask_mem[wdf_wptr_q] <= app.app_wdf_mask;
    end
  end

  // One RAM per byte lane gives byte-write enables; contents survive reset.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      logic [7:0] lane_rd_q;

      always_ff @(posedge sys_clk_i) begin
        if (wr_commit && !wr_mask[gi]) begin
          lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
        if (rd_acc) begin
          lane_rd_q <= lane_mem[cmd_idx];
        end
      end

      assign mem_rd_word[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      logic rd_seen_q;

      always_ff @(posedge sys_clk_i or negedge sys_rst) begin
        if (!sys_rst) begin
          rd_seen_q <= 1'b0;
        end else if (rd_acc) begin
          rd_seen_q <= 1'b1;
        end
      end

      assign app.app_rd_data = rd_seen_q ? mem_rd_word : '0;
    end else begin : g_latn
      logic [APP_DATA_WIDTH-1:0] pipe_q [RD_LATENCY-1];

      // Each stage only advances with its valid bit, so the last stage holds between reads.
      always_ff @(posedge sys_clk_i or negedge sys_rst) begin
        if (!sys_rst) begin
          for (int i = 0; i < RD_LATENCY - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          if (rd_vld_q[0]) begin
            pipe_q[0] <= mem_rd_word;
          end
          for (int i = 1; i < RD_LATENCY - 1; i++) begin
            if (rd_vld_q[i]) begin
              pipe_q[i] <= pipe_q[i-1];
            end
          end
        end
      end

      assign app.app_rd_data = pipe_q[RD_LATENCY-2];
    end
  endgenerate

  assign app.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
  assign init_calib_complete   = (state_q != ST_CALIB);
  assign ui_clk_sync_rst       = sync_rst_q;

endmodule

// File: tb/tb_app_mem_responder.sv
// Self-checking bench for app_mem_responder: vector table plus hand sequences,
// read responses checked by a scoreboard queue for data and exact cycle.
module tb_app_mem_responder;

  localparam int RD_LAT = 4;

  typedef struct {
    logic [27:0]  waddr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic [27:0]  raddr;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    int           exp_cyc;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic init_calib_complete;
  logic ui_clk_sync_rst;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  sb_t  sb [$];
  sb_t  mon_e;

  vec_t         tbl [7];
  logic [127:0] beats [4];

  app_mem_responder_if #(.ADDR_WIDTH(28), .APP_DATA_WIDTH(128)) bus ();

  app_mem_responder dut (
    .sys_clk_i           (clk),
    .sys_rst             (rst_n),
    .app                 (bus),
    .init_calib_complete (init_calib_complete),
    .ui_clk_sync_rst     (ui_clk_sync_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-response monitor.
  always @(negedge clk) begin
    if (bus.app_rd_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: valid at cycle %0d with no read outstanding, data %h", cyc, bus.app_rd_data);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (cyc != mon_e.exp_cyc) begin
          n_fail++;
          $display("FAIL rd_latency: valid at cycle %0d, required cycle %0d", cyc, mon_e.exp_cyc);
        end
        n_checks++;
        if (bus.app_rd_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL rd_data: got %h, required %h", bus.app_rd_data, mon_e.data);
        end
        n_checks++;
        if (bus.app_rd_data_end !== 1'b1) begin
          n_fail++;
          $display("FAIL rd_end: got %b with valid high, required 1", bus.app_rd_data_end);
        end
        $display("read response cycle %0d data %h", cyc, bus.app_rd_data);
      end
    end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_missing: no valid by cycle %0d, required at cycle %0d", cyc, sb[0].exp_cyc);
      void'(sb.pop_front());
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(input bit need_cmd, input bit need_wdf, input string nm);
    int n;
    n = 0;
    while (!((!need_cmd || bus.app_rdy === 1'b1) && (!need_wdf || bus.app_wdf_rdy === 1'b1)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: ready timeout, got app_rdy=%b app_wdf_rdy=%b, required 1", nm, bus.app_rdy, bus.app_wdf_rdy);
    end
  endtask

  task automatic do_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask, input bit with_data);
    wait_rdy(1'b1, with_data, "wr_ready");
    bus.app_en  = 1'b1;
    bus.app_cmd = 3'b000;
    bus.app_addr = addr;
    if (with_data) begin
      bus.app_wdf_wren = 1'b1;
      bus.app_wdf_data = data;
      bus.app_wdf_mask = mask;
    end
    $display("write cmd addr %h data %h mask %h with_data %0d", addr, data, mask, with_data);
    @(negedge clk);
    bus.app_en       = 1'b0;
    bus.app_wdf_wren = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] addr, input logic [127:0] exp, input bit expect_resp);
    sb_t e;
    wait_rdy(1'b1, 1'b0, "rd_ready");
    bus.app_en   = 1'b1;
    bus.app_cmd  = 3'b001;
    bus.app_addr = addr;
    if (expect_resp) begin
      e.data    = exp;
      e.exp_cyc = cyc + RD_LAT;
      sb.push_back(e);
    end
    $display("read cmd addr %h expect %h", addr, exp);
    @(negedge clk);
    bus.app_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d responses still outstanding, required 0", nm, sb.size());
    end
  endtask

  task automatic wait_calib();
    int n;
    n = 0;
    while (init_calib_complete !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("recalib_done", {127'd0, init_calib_complete}, 128'd1);
  endtask

  initial begin
    bit early;

    tbl[0] = '{28'h0000008, 128'hF00D_0001_0002_0003_0004_0005_012A_4020, 16'h0000,
               28'h0000008, 128'hF00D_0001_0002_0003_0004_0005_012A_4020};
    tbl[1] = '{28'h0002000, 128'h0, 16'h0000, 28'h0000000, 128'h0};
    tbl[2] = '{28'h0000000, {128{1'b1}}, 16'hFFF0, 28'h0002000, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF};
    tbl[3] = '{28'h0000007, {16{8'hA5}}, 16'hFFFF, 28'h0000000, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF};
    tbl[4] = '{28'h0001FF8, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE, 16'h0000,
               28'hFFFFFF8, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE};
    tbl[5] = '{28'h0000018, {16{8'h11}}, 16'h0000, 28'h0000018, {16{8'h11}}};
    tbl[6] = '{28'h0000018, {16{8'h22}}, 16'h0F0F, 28'h000001B, 128'h2222_2222_1111_1111_2222_2222_1111_1111};

    beats[0] = 128'hB000_0000_0000_0000_0000_0000_0000_00A0;
    beats[1] = 128'hB111_0000_0000_0000_0000_0000_0000_00A1;
    beats[2] = 128'hB222_0000_0000_0000_0000_0000_0000_00A2;
    beats[3] = 128'hB333_0000_0000_0000_0000_0000_0000_00A3;

    bus.app_addr     = '0;
    bus.app_cmd      = 3'b000;
    bus.app_en       = 1'b0;
    bus.app_wdf_data = '0;
    bus.app_wdf_mask = '0;
    bus.app_wdf_end  = 1'b1;
    bus.app_wdf_wren = 1'b0;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_app_rdy",    {127'd0, bus.app_rdy}, 128'd0);
    check("rst_wdf_rdy",    {127'd0, bus.app_wdf_rdy}, 128'd0);
    check("rst_valid",      {127'd0, bus.app_rd_data_valid}, 128'd0);
    check("rst_end",        {127'd0, bus.app_rd_data_end}, 128'd0);
    check("rst_calib",      {127'd0, init_calib_complete}, 128'd0);
    check("rst_rd_data",    bus.app_rd_data, 128'd0);
    check("rst_sync_rst",   {127'd0, ui_clk_sync_rst}, 128'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sync_rst_at_release", {127'd0, ui_clk_sync_rst}, 128'd1);

    // Calibration: nothing usable until the 64th edge after release.
    early = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      if (k == 1) check("sync_rst_after_1", {127'd0, ui_clk_sync_rst}, 128'd0);
      if (init_calib_complete !== 1'b0 || bus.app_rdy !== 1'b0 || bus.app_wdf_rdy !== 1'b0) early = 1'b1;
    end
    check("calib_early", {127'd0, early}, 128'd0);
    @(negedge clk);
    check("calib_done_64",   {127'd0, init_calib_complete}, 128'd1);
    check("app_rdy_64",      {127'd0, bus.app_rdy}, 128'd1);
    check("wdf_rdy_64",      {127'd0, bus.app_wdf_rdy}, 128'd1);

    // Table: write with data in the same cycle, then read back immediately.
    for (int i = 0; i < 7; i++) begin
      do_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wmask, 1'b1);
      do_read(tbl[i].raddr, tbl[i].exp, 1'b1);
    end
    drain("table_drain");
    repeat (3) @(negedge clk);
    check("rd_data_hold", bus.app_rd_data, tbl[6].exp);

    // Command first, data three cycles later.
    do_write(28'h10, 128'h0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("wait_wdata_app_rdy", {127'd0, bus.app_rdy}, 128'd0);
      @(negedge clk);
    end
    wait_rdy(1'b0, 1'b1, "late_wdf_ready");
    bus.app_wdf_wren = 1'b1;
    bus.app_wdf_data = 128'h0BAD_F00D_CAFE_0000_1234_5678_34CE_0002;
    bus.app_wdf_mask = 16'h0000;
    $display("late wdf beat %h", bus.app_wdf_data);
    @(negedge clk);
    bus.app_wdf_wren = 1'b0;
    check("after_late_app_rdy", {127'd0, bus.app_rdy}, 128'd1);
    do_read(28'h10, 128'h0BAD_F00D_CAFE_0000_1234_5678_34CE_0002, 1'b1);
    drain("late_drain");

    // Pre-buffer four beats; the fifth is refused.
    for (int k = 0; k < 4; k++) begin
      wait_rdy(1'b0, 1'b1, "fifo_push_ready");
      bus.app_wdf_wren = 1'b1;
      bus.app_wdf_data = beats[k];
      bus.app_wdf_mask = 16'h0000;
      $display("wdf push %0d data %h", k, beats[k]);
      @(negedge clk);
    end
    bus.app_wdf_data = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    check("fifo_full_wdf_rdy", {127'd0, bus.app_wdf_rdy}, 128'd0);
    @(negedge clk);
    bus.app_wdf_wren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_write(28'(k * 8), 128'h0, 16'h0, 1'b0);
    end
    check("fifo_drained_wdf_rdy", {127'd0, bus.app_wdf_rdy}, 128'd1);
    for (int k = 0; k < 4; k++) begin
      do_read(28'(k * 8), beats[k], 1'b1);
    end
    drain("fifo_drain");

    // Reads in flight are discarded by reset; memory persists.
    for (int k = 0; k < 3; k++) begin
      do_read(28'h08, 128'h0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_valid",   {127'd0, bus.app_rd_data_valid}, 128'd0);
    check("midrst_rd_data", bus.app_rd_data, 128'd0);
    check("midrst_sync",    {127'd0, ui_clk_sync_rst}, 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_calib();
    do_read(28'h18, beats[3], 1'b1);
    do_read(28'h10, beats[2], 1'b1);
    drain("persist_drain");
    repeat (8) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/app_mem_responder.md
Name: app_mem_responder

Overview:
- Responder end of the DDR3 controller application interface (app_* command, write-data and read-data channels).
- Drop-in stand-in for ExternalMemory in simulation and in small on-chip builds. Backs the interface with an internal block-RAM array instead of DDR3.
- Lets InstructionMemory and future data-memory initiators run unchanged without the memory controller.

Parameters:
- ADDR_WIDTH, 28, width of app_addr.
- APP_DATA_WIDTH, 128, width of one app data beat.
- MEM_DEPTH_LOG2, 10, log2 of the number of APP_DATA_WIDTH words stored.
- RD_LATENCY, 4, cycles from read command accept to app_rd_data_valid. Legal range 1..15.
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
- WDF_DEPTH_LOG2, 2, log2 of write-data FIFO depth.

Ports:
- sys_clk_i  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- app_addr  in  ADDR_WIDTH  command address, in column units.
- app_cmd  in  3  000 write, 001 read, others ignored.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en and app_rdy are both high.
- app_wdf_data  in  APP_DATA_WIDTH  write data.
- app_wdf_mask  in  APP_DATA_WIDTH/8  byte mask; 1 = byte not written.
- app_wdf_end  in  1  last beat; always 1 here, sampled but unused.
- app_wdf_wren  in  1  write data valid.
- app_wdf_rdy  out  1  write data accepted when app_wdf_wren and app_wdf_rdy are both high.
- app_rd_data  out  APP_DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data strobe.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  interface usable.
- ui_clk_sync_rst  out  1  active-high; asserted while sys_rst is low and one cycle after release.

Behaviour:
- Reset values (sys_rst low):
  - app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete = 0; app_rd_data = 0; ui_clk_sync_rst = 1.
  - Write-data FIFO, read pipeline and calibration counter cleared.
  - Memory array contents NOT reset; they persist across reset.
- Reset mid-operation: in-flight reads are discarded (no valid pulse is ever produced for them); buffered write data is dropped; calibration restarts from 0.
- Calibration: counter runs from reset release. init_calib_complete rises on cycle CALIB_CYCLES and stays high. app_rdy and app_wdf_rdy remain 0 until then.
- States:
  - CALIB: counting; goes to IDLE when the count reaches CALIB_CYCLES.
  - IDLE: app_rdy = 1.
    - Write accepted with FIFO non-empty: pop the head word and commit it to the array this cycle.
    - Write accepted with FIFO empty: latch the address and go to WAIT_WDATA.
    - Read accepted: array read; result enters the latency pipeline.
    - Other cmd values: accepted and dropped.
  - WAIT_WDATA: app_rdy = 0. When a write-data beat is accepted, bypass it straight to the array at the latched address and return to IDLE.
- Write-data FIFO:
  - Holds data and mask per entry. app_wdf_rdy = not full, valid only after calibration.
  - Data may arrive before, with, or after its command; beats pair with write commands in FIFO order.
  - Push and pop in the same cycle when full: the pop frees the slot, but app_wdf_rdy is computed from pre-pop occupancy and stays 0 that cycle.
- Address map:
  - Word index = app_addr[MEM_DEPTH_LOG2+2:3]. app_addr[2:0] is ignored.
  - Address bits above the index are ignored, so addresses wrap modulo 2^MEM_DEPTH_LOG2.
- Byte mask: byte k is written only if mask bit k = 0. A mask of all ones leaves the word unchanged.
- Reads:
  - Read accepted in cycle N: app_rd_data_valid is high for one cycle in cycle N+RD_LATENCY.
  - Responses are in order, with no gaps imposed; back-to-back reads give back-to-back valids.
  - app_rd_data holds its last value when not valid.
- Hazards: a read accepted in the cycle after a write commit returns the new data, i.e. the write-first ordering the array provides.
- One command per cycle. Throughput is one read or one write per cycle when write data is pre-buffered.

Optional Feature:
- Macro RESP_BACKPRESSURE_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, reset to seed) forces app_rdy = 0 whenever its low two bits are 00.
  - A second tap, bits [3:2] = 00, forces app_wdf_rdy = 0.
  - Used to stress initiator handshakes.
- Undefined: no LFSR is built; ready signals follow the rules above only.

Test Plan:
- Reset, then idle, CALIB_CYCLES=64 -> init_calib_complete, app_rdy and app_wdf_rdy all rise in cycle 64 after release, and not before.
- Write addr 0x08 with data 0x...012A4020 and mask 0 (data and command in the same cycle), then read addr 0x08 -> valid exactly 4 cycles after read accept, data = 0x...012A4020, rd_data_end = valid.
- Write command at addr 0x10 with no data; 3 cycles later wdf beat 0x...34CE0002 -> app_rdy low for those cycles; a subsequent read of 0x10 returns 0x...34CE0002.
- Push 4 wdf beats with no commands -> app_wdf_rdy low on the 5th attempt. Then 4 write commands to 0x00, 0x08, 0x10, 0x18, followed by 4 back-to-back reads -> 4 consecutive valids carrying the data in the order pushed.
- Mask 16'hFFF0 write of all-ones over a word holding 0 -> readback = 0x000...0FFFFFFFF. Address 0x2000 with MEM_DEPTH_LOG2=10 aliases to word 0.
- 3 reads in flight, then sys_rst pulsed low -> no app_rd_data_valid ever appears for them; after re-calibration, earlier-written data is still readable.
